// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// register-select width and the scoreboard entry layout.
package hazard_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    function automatic logic entry_match(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.v && (e.rd == r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB writer scoreboard with read-select hit compare.
// The WB entry is left out of the compare when the register file bypasses.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_ex_v,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_rd1,
    input  logic [REG_W-1:0] i_rd2,
    output logic             o_hit1,
    output logic             o_hit2,
    output logic             o_any_v
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;
    logic      w_wb_cmp;

    assign w_wb_cmp = (WB_BYPASS == 1'b0);

    // Shift writers down the pipe only when the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (i_adv) begin
            r_ex.v  <= i_ex_v;
            r_ex.rd <= i_ex_rd;
            r_mem   <= r_ex;
            r_wb    <= r_mem;
        end else begin
            r_ex  <= r_ex;
            r_mem <= r_mem;
            r_wb  <= r_wb;
        end
    end

    // Hit compare of both decode read selects against the live window.
    always_comb begin
        o_hit1  = entry_match(r_ex, i_rd1) | entry_match(r_mem, i_rd1)
                | (entry_match(r_wb, i_rd1) & w_wb_cmp);
        o_hit2  = entry_match(r_ex, i_rd2) | entry_match(r_mem, i_rd2)
                | (entry_match(r_wb, i_rd2) & w_wb_cmp);
        o_any_v = r_ex.v | r_mem.v | r_wb.v;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: RAW stall, branch flush, memory
// freeze and halt drain, with a saturating RAW-stall cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRd1Sel,
    input  logic [REG_W-1:0] idRd2Sel,
    input  logic             idUse1,
    input  logic             idUse2,
    input  logic             idRegWrt,
    input  logic [REG_W-1:0] idWriteReg,
    input  logic             idHalt,
    input  logic             exBrTaken,
    input  logic             memBusy,
    output logic             pcWrtEn,
    output logic             ifIdWrtEn,
    output logic             ifIdFlush,
    output logic             idExBubble,
    output logic             pipeEn,
    output logic             haltDone,
    output logic [CNT_W-1:0] stallCnt
);

    hz_state_e        r_state;
    hz_state_e        w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_any_v;
    logic             w_run;
    logic             w_raw;
    logic             w_issue;
    logic             w_stall_inc;

    hazard_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (pipeEn),
        .i_ex_v  (idValid & idRegWrt & w_issue),
        .i_ex_rd (idWriteReg),
        .i_rd1   (idRd1Sel),
        .i_rd2   (idRd2Sel),
        .o_hit1  (w_hit1),
        .o_hit2  (w_hit2),
        .o_any_v (w_any_v)
    );

    // Priority memBusy > flush > RAW only applies while running; DRAIN ignores both.
    assign w_run       = (r_state == ST_RUN);
    assign w_raw       = idValid & ((idUse1 & w_hit1) | (idUse2 & w_hit2));
    assign w_issue     = w_run & ~memBusy & ~exBrTaken & ~w_raw;
    assign w_stall_inc = w_run & ~memBusy & ~exBrTaken & w_raw;
    assign stallCnt    = r_stall_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a halt must actually issue before draining starts.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_issue && idValid && idHalt) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!w_any_v && !memBusy) begin
                    w_next_state = ST_HALTED;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_HALTED: w_next_state = ST_HALTED;
            default:   w_next_state = ST_RUN;
        endcase
    end

    // Enable and bubble selects from state and the per-cycle priority mux.
    always_comb begin
        pcWrtEn    = 1'b0;
        ifIdWrtEn  = 1'b0;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        pipeEn     = 1'b0;
        haltDone   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (memBusy) begin
                    pipeEn = 1'b0;
                end else if (exBrTaken) begin
                    pcWrtEn    = 1'b1;
                    ifIdWrtEn  = 1'b1;
                    ifIdFlush  = 1'b1;
                    idExBubble = 1'b1;
                    pipeEn     = 1'b1;
                end else if (w_raw) begin
                    idExBubble = 1'b1;
                    pipeEn     = 1'b1;
                end else begin
                    pcWrtEn   = 1'b1;
                    ifIdWrtEn = 1'b1;
                    pipeEn    = 1'b1;
                end
            end
            ST_DRAIN: begin
                idExBubble = 1'b1;
                pipeEn     = ~memBusy;
            end
            ST_HALTED: haltDone = 1'b1;
            default:   haltDone = 1'b0;
        endcase
    end

    // Saturating count of RAW-stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand sequences
// for bypass/saturation/reset, and randomized stimulus against a reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       idValid;
    logic [2:0] idRd1Sel;
    logic [2:0] idRd2Sel;
    logic       idUse1;
    logic       idUse2;
    logic       idRegWrt;
    logic [2:0] idWriteReg;
    logic       idHalt;
    logic       exBrTaken;
    logic       memBusy;

    logic        pc_a, ifid_a, fl_a, bub_a, pipe_a, hd_a;
    logic [3:0]  cnt_a;
    logic        pc_b, ifid_b, fl_b, bub_b, pipe_b, hd_b;
    logic [15:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .idValid(idValid), .idRd1Sel(idRd1Sel), .idRd2Sel(idRd2Sel),
        .idUse1(idUse1), .idUse2(idUse2), .idRegWrt(idRegWrt), .idWriteReg(idWriteReg),
        .idHalt(idHalt), .exBrTaken(exBrTaken), .memBusy(memBusy),
        .pcWrtEn(pc_a), .ifIdWrtEn(ifid_a), .ifIdFlush(fl_a), .idExBubble(bub_a),
        .pipeEn(pipe_a), .haltDone(hd_a), .stallCnt(cnt_a)
    );

    hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .idValid(idValid), .idRd1Sel(idRd1Sel), .idRd2Sel(idRd2Sel),
        .idUse1(idUse1), .idUse2(idUse2), .idRegWrt(idRegWrt), .idWriteReg(idWriteReg),
        .idHalt(idHalt), .exBrTaken(exBrTaken), .memBusy(memBusy),
        .pcWrtEn(pc_b), .ifIdWrtEn(ifid_b), .ifIdFlush(fl_b), .idExBubble(bub_b),
        .pipeEn(pipe_b), .haltDone(hd_b), .stallCnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {pcWrtEn, ifIdWrtEn, ifIdFlush, idExBubble, pipeEn, haltDone}
    localparam logic [5:0] NORM = 6'b110010;
    localparam logic [5:0] STL  = 6'b000110;
    localparam logic [5:0] FLSH = 6'b111110;
    localparam logic [5:0] FRZ  = 6'b000000;
    localparam logic [5:0] DRNB = 6'b000100;
    localparam logic [5:0] HLT  = 6'b000001;

    typedef struct {
        logic       v;
        logic [2:0] rd1;
        logic [2:0] rd2;
        logic       u1;
        logic       u2;
        logic       wr;
        logic [2:0] wreg;
        logic       halt;
        logic       br;
        logic       busy;
        logic [5:0] exp;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic v, input logic [2:0] rd1, input logic [2:0] rd2,
                                input logic u1, input logic u2, input logic wr, input logic [2:0] wreg,
                                input logic halt, input logic br, input logic busy,
                                input logic [5:0] exp, input logic [3:0] cnt);
        vec_t t;
        t.v = v; t.rd1 = rd1; t.rd2 = rd2; t.u1 = u1; t.u2 = u2; t.wr = wr; t.wreg = wreg;
        t.halt = halt; t.br = br; t.busy = busy; t.exp = exp; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic set_idle();
        idValid = 1'b0; idRd1Sel = 3'd0; idRd2Sel = 3'd0; idUse1 = 1'b0; idUse2 = 1'b0;
        idRegWrt = 1'b0; idWriteReg = 3'd0; idHalt = 1'b0; exBrTaken = 1'b0; memBusy = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        idValid = t.v; idRd1Sel = t.rd1; idRd2Sel = t.rd2; idUse1 = t.u1; idUse2 = t.u2;
        idRegWrt = t.wr; idWriteReg = t.wreg; idHalt = t.halt; exBrTaken = t.br; memBusy = t.busy;
    endtask

    // Reset with memBusy and a branch pending, then confirm both DUTs are back in RUN.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; memBusy = 1'b1; exBrTaken = 1'b1; idValid = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_haltDone_a", {31'd0, hd_a}, 32'd0);
        chk("rst_cnt_a", {28'd0, cnt_a}, 32'd0);
        chk("rst_cnt_b", {16'd0, cnt_b}, 32'd0);
        rst = 1'b0;
        set_idle();
        #1;
        chk("rst_run_a", {26'd0, pc_a, ifid_a, fl_a, bub_a, pipe_a, hd_a}, {26'd0, NORM});
        chk("rst_run_b", {26'd0, pc_b, ifid_b, fl_b, bub_b, pipe_b, hd_b}, {26'd0, NORM});
    endtask

    // Writer to wr_reg followed by a reader of rd_reg held for six cycles.
    task automatic stall_seq(input logic [2:0] wr_reg, input logic [2:0] rd_reg,
                             input int exp_a, input int exp_b);
        int sa = 0;
        int sb = 0;
        do_reset();
        @(negedge clk);
        idValid = 1'b1; idRegWrt = 1'b1; idWriteReg = wr_reg;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idValid = 1'b1; idRegWrt = 1'b0; idUse1 = 1'b1; idRd1Sel = rd_reg;
            #1;
            if (!pc_a) sa++;
            if (!pc_b) sb++;
        end
        chk("stall_cycles_a", sa, exp_a);
        chk("stall_cycles_b", sb, exp_b);
        @(negedge clk);
        set_idle();
        #1;
        chk("stall_cnt_a", {28'd0, cnt_a}, exp_a);
        chk("stall_cnt_b", {16'd0, cnt_b}, exp_b);
    endtask

    // Reference model: per DUT, a list of in-flight writers (oldest last) and a mode.
    bit mv[2][3];
    int mr[2][3];
    int mst[2];
    int mcnt[2];
    int mmax[2] = '{15, 65535};
    int mwin[2] = '{3, 2};

    task automatic model_eval(input int k, output logic [5:0] exp, output bit raw, output bit issue);
        bit h1 = 0;
        bit h2 = 0;
        for (int i = 0; i < mwin[k]; i++) begin
            if (mv[k][i] && mr[k][i] == int'(idRd1Sel)) h1 = 1;
            if (mv[k][i] && mr[k][i] == int'(idRd2Sel)) h2 = 1;
        end
        raw = idValid && ((idUse1 && h1) || (idUse2 && h2));
        issue = 0;
        if (mst[k] == 0) begin
            if (memBusy) exp = FRZ;
            else if (exBrTaken) exp = FLSH;
            else if (raw) exp = STL;
            else begin exp = NORM; issue = 1; end
        end else if (mst[k] == 1) begin
            exp = memBusy ? DRNB : STL;
        end else begin
            exp = HLT;
        end
    endtask

    task automatic model_step(input int k);
        logic [5:0] e;
        bit raw, issue, any;
        model_eval(k, e, raw, issue);
        if (rst) begin
            for (int i = 0; i < 3; i++) mv[k][i] = 0;
            mst[k] = 0;
            mcnt[k] = 0;
        end else begin
            any = mv[k][0] || mv[k][1] || mv[k][2];
            if (mst[k] == 0 && !memBusy && !exBrTaken && raw && mcnt[k] < mmax[k]) mcnt[k]++;
            if (mst[k] != 2 && !memBusy) begin
                mv[k][2] = mv[k][1]; mr[k][2] = mr[k][1];
                mv[k][1] = mv[k][0]; mr[k][1] = mr[k][0];
                mv[k][0] = idValid && idRegWrt && issue; mr[k][0] = int'(idWriteReg);
            end
            if (mst[k] == 0 && issue && idValid && idHalt) mst[k] = 1;
            else if (mst[k] == 1 && !any && !memBusy) mst[k] = 2;
        end
    endtask

    initial begin
        logic [5:0] ea, eb;
        bit ra, ia;
        rst = 1'b1;
        set_idle();

        tbl[0]  = mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, NORM, 4'd0);
        tbl[1]  = mk(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, NORM, 4'd0);
        tbl[2]  = mk(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, STL,  4'd0);
        tbl[3]  = mk(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, STL,  4'd1);
        tbl[4]  = mk(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, STL,  4'd2);
        tbl[5]  = mk(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, NORM, 4'd3);
        tbl[6]  = mk(1'b1, 3'd5, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, NORM, 4'd3);
        tbl[7]  = mk(1'b1, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, FLSH, 4'd3);
        tbl[8]  = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, NORM, 4'd3);
        for (int i = 9; i < 13; i++)
            tbl[i] = mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, FRZ, 4'd3);
        tbl[13] = mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, FLSH, 4'd3);
        tbl[14] = mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, STL,  4'd3);
        tbl[15] = mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, STL,  4'd4);
        tbl[16] = mk(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, NORM, 4'd5);
        tbl[17] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, NORM, 4'd5);
        tbl[18] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, NORM, 4'd5);
        tbl[19] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, NORM, 4'd5);
        tbl[20] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, STL,  4'd5);
        tbl[21] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, DRNB, 4'd5);
        tbl[22] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, STL,  4'd5);
        tbl[23] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, STL,  4'd5);
        tbl[24] = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, HLT,  4'd5);
        tbl[25] = mk(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, HLT,  4'd5);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk($sformatf("vec%0d_outs", i), {26'd0, pc_a, ifid_a, fl_a, bub_a, pipe_a, hd_a}, {26'd0, tbl[i].exp});
            chk($sformatf("vec%0d_cnt", i), {28'd0, cnt_a}, {28'd0, tbl[i].cnt});
        end

        // Reset out of HALTED with memBusy high, then bypass and independent-register cases.
        do_reset();
        stall_seq(3'd3, 3'd3, 3, 2);
        stall_seq(3'd3, 3'd5, 0, 0);

        // Self-dependent instruction held for 40 cycles drives the 4-bit counter into saturation.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            idValid = 1'b1; idUse1 = 1'b1; idRd1Sel = 3'd7; idRegWrt = 1'b1; idWriteReg = 3'd7;
        end
        @(negedge clk);
        set_idle();
        #1;
        chk("sat_cnt_a", {28'd0, cnt_a}, 32'hF);
        chk("sat_cnt_b", {16'd0, cnt_b}, 32'd26);

        // Randomized run against the reference model.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin mv[k][i] = 0; mr[k][i] = 0; end
            mst[k] = 0;
            mcnt[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 99) < 2);
            idValid    = ($urandom_range(0, 99) < 80);
            idRd1Sel   = 3'($urandom_range(0, 3));
            idRd2Sel   = 3'($urandom_range(0, 3));
            idUse1     = 1'($urandom_range(0, 1));
            idUse2     = 1'($urandom_range(0, 1));
            idRegWrt   = ($urandom_range(0, 99) < 60);
            idWriteReg = 3'($urandom_range(0, 3));
            idHalt     = ($urandom_range(0, 99) < 3);
            exBrTaken  = ($urandom_range(0, 99) < 10);
            memBusy    = ($urandom_range(0, 99) < 20);
            #1;
            model_eval(0, ea, ra, ia);
            model_eval(1, eb, ra, ia);
            chk("rand_outs_a", {26'd0, pc_a, ifid_a, fl_a, bub_a, pipe_a, hd_a}, {26'd0, ea});
            chk("rand_outs_b", {26'd0, pc_b, ifid_b, fl_b, bub_b, pipe_b, hd_b}, {26'd0, eb});
            chk("rand_cnt_a", {28'd0, cnt_a}, mcnt[0]);
            chk("rand_cnt_b", {16'd0, cnt_b}, mcnt[1]);
            model_step(0);
            model_step(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
